// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants for the key-schedule slice.
//   AES_NUM_ROUNDS / AES_KEY_W : AES-128 geometry
//   keyExpState_e              : key expander FSM encoding (ST_REPLAY is only
//                                reachable when AES_KEYEXP_REVERSE_EN is defined)
//   rcon()                     : round constant for transformation index 0..9
//   sbox()                     : forward AES S-box, the same table the subBytes stage uses
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_KEY_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_REPLAY = 2'd2
  } keyExpState_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sub_word.sv
// sub_word: combinational AES SubWord, one S-box lookup per byte lane.
//   wordIn  [31:0] : input word
//   wordOut [31:0] : S-box substituted word
module sub_word
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] wordIn,
  output logic [NUM_LANES-1:0][7:0] wordOut
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    assign wordOut[i] = sbox(wordIn[i]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: sequential AES-128 key schedule. Loads a cipher key on
// start and streams round keys 0..10 over a valid/ready handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, key_in  : load pulse and cipher key (key_in[127:96] is w0)
//   busy           : a stream is in progress
//   rk_valid/ready : round-key handshake, transfer = rk_valid & rk_ready
//   rk_out, rk_idx : current round key and its round number
//   done           : one-cycle pulse after round key 10 (or 0 in replay) transfers
// Optional (macro AES_KEYEXP_REVERSE_EN): rev_start, keys_stored and an 11-entry
// key store that lets the last expansion be replayed from key 10 down to key 0.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,  // only 10 is supported
  parameter int KEY_W      = AES_KEY_W        // only 128 is supported
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             done
`ifdef AES_KEYEXP_REVERSE_EN
  ,
  input  logic             rev_start,
  output logic             keys_stored
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  keyExpState_e state;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rotW, subW, tWord;
  logic [31:0] n0, n1, n2, n3;
  logic [KEY_W-1:0] nextKey;
  logic xfer;

  // next(): one AES-128 key-schedule step on the current round key
  assign {w0, w1, w2, w3} = rk_out;
  assign rotW  = {w3[23:0], w3[31:24]};

  sub_word #(.NUM_LANES(4)) uSubWord (
    .wordIn (rotW),
    .wordOut(subW)
  );

  assign tWord   = subW ^ {rcon(rk_idx), 24'h0};
  assign n0      = w0 ^ tWord;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign nextKey = {n0, n1, n2, n3};

  assign xfer = rk_valid & rk_ready;

`ifdef AES_KEYEXP_REVERSE_EN
  logic [KEY_W-1:0] keyStore [NUM_ROUNDS+1];

  // Every forward key is captured as it leaves, so a completed expansion
  // leaves keys 0..10 in place for replay.
  always_ff @(posedge clk) begin
    if (state == ST_EMIT && xfer) keyStore[rk_idx] <= rk_out;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
`ifdef AES_KEYEXP_REVERSE_EN
      keys_stored <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rk_out   <= key_in;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_EMIT;
`ifdef AES_KEYEXP_REVERSE_EN
            keys_stored <= 1'b0;
          end else if (rev_start && keys_stored) begin
            rk_out   <= keyStore[LAST_IDX];
            rk_idx   <= LAST_IDX;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_REPLAY;
`endif
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            if (rk_idx == LAST_IDX) begin
              // rk_out deliberately keeps round key 10
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
`ifdef AES_KEYEXP_REVERSE_EN
              keys_stored <= 1'b1;
`endif
            end else begin
              rk_out <= nextKey;
              rk_idx <= rk_idx + 4'd1;
            end
          end
        end
`ifdef AES_KEYEXP_REVERSE_EN
        ST_REPLAY: begin
          if (xfer) begin
            if (rk_idx == 4'd0) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              rk_out <= keyStore[rk_idx - 4'd1];
              rk_idx <= rk_idx - 4'd1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed checks of the AES-128 key expander against
// FIPS-197 key schedules. Define AES_KEYEXP_REVERSE_EN to also cover replay.
module tb_aes_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;
`ifdef AES_KEYEXP_REVERSE_EN
  logic         rev_start;
  logic         keys_stored;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] V1 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expander dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
`ifdef AES_KEYEXP_REVERSE_EN
    ,
    .rev_start  (rev_start),
    .keys_stored(keys_stored)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Run one stream to completion. mode 0 = vector-1 schedule, mode 1 = zero key.
  // pA/pB: transfer numbers during which a stray start is pulsed.
  task automatic stream(input logic [127:0] key, input int mode, input bit doStart,
                        input bit throttle, input bit rev, input int pA, input int pB);
    int n, cyc, ei;
    bit stalled;
    logic [127:0] pOut;
    logic [3:0]   pIdx;
    n = 0; cyc = 0; stalled = 0; pOut = '0; pIdx = '0;
    if (doStart) begin
      key_in = key;
`ifdef AES_KEYEXP_REVERSE_EN
      if (rev) rev_start = 1'b1;
      else     start = 1'b1;
`else
      start = 1'b1;
`endif
      @(negedge clk);
      start = 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
      rev_start = 1'b0;
`endif
      chk("lat_valid", 128'(rk_valid), 128'd1);
      chk("lat_busy", 128'(busy), 128'd1);
    end
    key_in = '0;  // a wrongly accepted start would show up as the zero-key schedule
    while (n < 11 && cyc < 400) begin
      chk("no_early_done", 128'(done), 128'd0);
      if (stalled) begin
        chk("stall_out", rk_out, pOut);
        chk("stall_idx", 128'(rk_idx), 128'(pIdx));
      end
      rk_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = 1'b0;
      if (rk_valid && rk_ready) begin
        ei = rev ? 10 - n : n;
        chk("idx", 128'(rk_idx), 128'(ei));
        if (mode == 0)     chk("key_v1", rk_out, V1[ei]);
        else if (ei == 0)  chk("key_z0", rk_out, 128'd0);
        else if (ei == 1)  chk("key_z1", rk_out, Z1);
        else if (ei == 10) chk("key_z10", rk_out, Z10);
        start   = (n == pA) || (n == pB);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = rk_valid;
        pOut    = rk_out;
        pIdx    = rk_idx;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("key_count", 128'(n), 128'd11);
    chk("done_pulse", 128'(done), 128'd1);
    chk("busy_end", 128'(busy), 128'd0);
    chk("valid_end", 128'(rk_valid), 128'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
    rev_start = 1'b0;
`endif
    #2;
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_out", rk_out, 128'd0);
    chk("rst_idx", 128'(rk_idx), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef AES_KEYEXP_REVERSE_EN
    // replay with nothing stored is ignored
    chk("rst_stored", 128'(keys_stored), 128'd0);
    rev_start = 1'b1;
    @(negedge clk);
    rev_start = 1'b0;
    chk("rev_ignored_valid", 128'(rk_valid), 128'd0);
    chk("rev_ignored_busy", 128'(busy), 128'd0);
    @(negedge clk);
`endif

    // 1: vector 1, always ready; done one cycle after key 10
    stream(V1[0], 0, 1, 0, 0, -1, -1);
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);
    chk("out_holds_last", rk_out, V1[10]);

    // 2: zero key
    stream('0, 1, 1, 0, 0, -1, -1);

    // 3: vector 1 with random back-pressure
    stream(V1[0], 0, 1, 1, 0, -1, -1);

`ifdef AES_KEYEXP_REVERSE_EN
    chk("stored_set", 128'(keys_stored), 128'd1);
    stream('0, 0, 1, 1, 1, -1, -1);
`endif

    // 4: stray starts at idx 4 and during the final transfer are ignored,
    //    start in the done cycle is accepted
    stream(V1[0], 0, 1, 0, 0, 4, 10);
    key_in = '0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_valid", 128'(rk_valid), 128'd1);
    chk("done_cycle_idx", 128'(rk_idx), 128'd0);
    chk("done_cycle_out", rk_out, 128'd0);
`ifdef AES_KEYEXP_REVERSE_EN
    chk("stored_cleared", 128'(keys_stored), 128'd0);
`endif
    stream('0, 1, 0, 0, 0, -1, -1);

    // 5: reset mid-stream at idx 6 clears outputs without a clock edge
    key_in = V1[0];
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_idx != 4'd6 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx6", 128'(rk_idx), 128'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(rk_valid), 128'd0);
    chk("async_busy", 128'(busy), 128'd0);
    chk("async_out", rk_out, 128'd0);
    chk("async_idx", 128'(rk_idx), 128'd0);
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream(V1[0], 0, 1, 0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
